result_drain_sequencer: RTL and testbench

- Host-side counterpart of the matrix-multiply DUT.
- Starts a DUT run with a dut_run / dut_busy handshake, then waits for the computation to finish.
- After the run, reads the result words back from the output SRAM through its read port (1-cycle read latency).
- Streams the words to the host/testbench over a valid/ready interface, buffered by a small FIFO.

---
 rtl/result_drain_sequencer.sv | 177 +++++++++++++++++
 tb/tb_result_drain_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain_sequencer.sv
// Host-side run/drain sequencer: kicks the matrix-multiply DUT, waits for it to finish,
// then streams the result words out of the output SRAM through a small credit-checked FIFO.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; all strobes low
// RUN_REQ   | one-cycle dut_run request
// WAIT_HI   | dut_run held until the DUT reports busy (timeout guarded)
// WAIT_LO   | waiting for the DUT to drop busy (timeout guarded)
// DRAIN     | issuing SRAM reads and streaming words until all are accepted
// FINISH    | one-cycle done pulse
module result_drain_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] result_base_addr,
    input  logic [ADDR_W-1:0] result_count,
    output logic              dut_run,
    input  logic              dut_busy,
    output logic [ADDR_W-1:0] host_sram_read_address,
    output logic              host_sram_read_enable,
    input  logic [DATA_W-1:0] sram_host_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_REQ,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] accepted;
    logic [TMO_W-1:0]  wait_cnt;
    logic              timeout_err_q;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic pop;
    logic push;
    logic wait_tc;
    logic timeout_fire;
    logic credit_ok;
    logic rd_issue;
    logic drain_done;

    assign pop     = (fifo_count != '0) && out_ready;
    assign push    = inflight;
    assign wait_tc = (wait_cnt == '0);

    // A word already in flight from the SRAM still needs a slot, so it counts against the credit.
    assign credit_ok  = (fifo_count + CNT_W'(inflight) - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
    assign rd_issue   = (state == S_DRAIN) && (issued < count_q) && credit_ok;
    assign drain_done = (accepted + ADDR_W'(pop)) == count_q;

    // Progress wins over the timeout if both happen on the terminal cycle.
    assign timeout_fire = wait_tc &&
                          (((state == S_WAIT_HI) && !dut_busy) ||
                           ((state == S_WAIT_LO) && dut_busy));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_RUN_REQ;
            S_RUN_REQ: state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (dut_busy)     state_next = S_WAIT_LO;
                else if (wait_tc) state_next = S_IDLE;
            end
            S_WAIT_LO: begin
                if (!dut_busy)    state_next = (count_q == '0) ? S_FINISH : S_DRAIN;
                else if (wait_tc) state_next = S_IDLE;
            end
            S_DRAIN:   if (drain_done) state_next = S_FINISH;
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dut_run                = (state == S_RUN_REQ) || (state == S_WAIT_HI);
        busy                   = (state != S_IDLE);
        done                   = (state == S_FINISH);
        host_sram_read_enable  = rd_issue;
        host_sram_read_address = rd_issue ? (base_q + issued) : '0;
        out_valid              = (fifo_count != '0);
        out_data               = fifo_mem[rd_ptr];
        timeout_err            = timeout_err_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            base_q        <= '0;
            count_q       <= '0;
            issued        <= '0;
            accepted      <= '0;
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
            inflight      <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                base_q        <= result_base_addr;
                count_q       <= result_count;
                issued        <= '0;
                accepted      <= '0;
                timeout_err_q <= 1'b0;
            end else begin
                if (timeout_fire) timeout_err_q <= 1'b1;
                if (rd_issue)     issued <= issued + ADDR_W'(1);
                if (pop)          accepted <= accepted + ADDR_W'(1);
            end
            inflight <= rd_issue;
            // Down-counter reloads on every state change, so each wait state gets a fresh budget.
            if (state_next != state) begin
                wait_cnt <= TMO_LOAD;
            end else if (!wait_tc) begin
                wait_cnt <= wait_cnt - TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_host_read_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_sequencer.sv
// Directed bench for result_drain_sequencer: vector table of runs plus hand-written
// timeout and mid-drain reset sequences.
module tb_result_drain_sequencer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              start;
    logic [ADDR_W-1:0] result_base_addr;
    logic [ADDR_W-1:0] result_count;
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] host_sram_read_address;
    logic              host_sram_read_enable;
    logic [DATA_W-1:0] sram_host_read_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              timeout_err;

    logic              t_start;
    logic [ADDR_W-1:0] t_base;
    logic [ADDR_W-1:0] t_count;
    logic              t_dut_run;
    logic              t_dut_busy;
    logic [ADDR_W-1:0] t_addr;
    logic              t_rd_en;
    logic [DATA_W-1:0] t_rdata;
    logic [DATA_W-1:0] t_out_data;
    logic              t_out_valid;
    logic              t_out_ready;
    logic              t_busy;
    logic              t_done;
    logic              t_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    result_drain_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)
    ) u_dut (
        .clk(clk), .reset_b(reset_b), .start(start),
        .result_base_addr(result_base_addr), .result_count(result_count),
        .dut_run(dut_run), .dut_busy(dut_busy),
        .host_sram_read_address(host_sram_read_address),
        .host_sram_read_enable(host_sram_read_enable),
        .sram_host_read_data(sram_host_read_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    result_drain_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)
    ) u_tmo (
        .clk(clk), .reset_b(reset_b), .start(t_start),
        .result_base_addr(t_base), .result_count(t_count),
        .dut_run(t_dut_run), .dut_busy(t_dut_busy),
        .host_sram_read_address(t_addr),
        .host_sram_read_enable(t_rd_en),
        .sram_host_read_data(t_rdata),
        .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .busy(t_busy), .done(t_done), .timeout_err(t_timeout_err)
    );

    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return {~a[3:0], a};
    endfunction

    // Output SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (host_sram_read_enable) sram_host_read_data <= mem_f(host_sram_read_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
        int                busy_len;
        bit                bp;
        bit                glitch;
        int                exp_reads;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v, input int abort_at);
        logic [ADDR_W-1:0] raddr[$];
        logic [DATA_W-1:0] got[$];
        int r = -1, f = -1;
        int nreads = 0, nacc = 0, ndone = 0, maxout = 0;
        int first_rd = -1, first_val = -1, first_acc = -1, last_acc = -1, done_cyc = -1;
        bit prev_stall = 0, aborted = 0;
        logic [DATA_W-1:0] prev_data = '0;
        string p;
        p = $sformatf("v%0d", id);

        @(negedge clk);
        result_base_addr = v.base;
        result_count     = v.cnt;
        start            = 1'b1;
        dut_busy         = 1'b0;
        out_ready        = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start            = 1'b0;
            result_base_addr = 12'hABC;
            result_count     = 12'h0FF;
            dut_busy  = (r >= 0 && k >= r + 2 && k < r + 2 + v.busy_len) ||
                        (v.glitch && f >= 0 && k == f + 2);
            out_ready = v.bp ? (k % 3 == 0) : 1'b1;
            #1;
            if (r < 0 && dut_run) begin
                r = k;
                f = r + 2 + v.busy_len;
            end
            if (r >= 0 && k == r + 2) check({p, "_run_hold"}, dut_run, 1);
            if (r >= 0 && k == r + 3) check({p, "_run_drop"}, dut_run, 0);
            if (host_sram_read_enable) begin
                raddr.push_back(host_sram_read_address);
                if (first_rd < 0) first_rd = k;
                nreads++;
            end
            if (out_valid && first_val < 0) first_val = k;
            if (prev_stall) begin
                check({p, "_stall_valid"}, out_valid, 1);
                check({p, "_stall_data"}, out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                nacc++;
                if (first_acc < 0) first_acc = k;
                last_acc = k;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (nreads - nacc > maxout) maxout = nreads - nacc;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (abort_at > 0 && nacc == abort_at) begin
                aborted = 1;
                break;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        if (aborted) return;

        check({p, "_done_pulse"}, ndone, 1);
        check({p, "_nreads"}, nreads, v.exp_reads);
        check({p, "_naccepted"}, nacc, v.cnt);
        check({p, "_outstanding"}, (maxout <= DEPTH), 1);
        for (int i = 0; i < raddr.size(); i++)
            check($sformatf("%s_addr%0d", p, i), raddr[i], ADDR_W'(v.base + ADDR_W'(i)));
        for (int i = 0; i < got.size(); i++)
            check($sformatf("%s_data%0d", p, i), got[i], mem_f(ADDR_W'(v.base + ADDR_W'(i))));
        if (v.exp_reads > 0 && raddr.size() > 0) begin
            check({p, "_first_addr"}, raddr[0], v.exp_first);
            check({p, "_last_addr"}, raddr[raddr.size()-1], v.exp_last);
        end
        if (v.cnt == 0) begin
            check({p, "_zero_done_cyc"}, done_cyc, f + 1);
        end else begin
            check({p, "_drain_start"}, first_rd, f + 1);
            check({p, "_first_valid"}, first_val, first_rd + 2);
            check({p, "_done_after_last"}, done_cyc, last_acc + 1);
            if (!v.bp) check({p, "_back_to_back"}, last_acc - first_acc, v.cnt - 1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int run_hi, tmo_k, ndone;

        vecs[0] = '{12'h010, 12'd4, 20, 1'b0, 1'b0, 4, 12'h010, 12'h013};
        vecs[1] = '{12'h100, 12'd8,  5, 1'b1, 1'b1, 8, 12'h100, 12'h107};
        vecs[2] = '{12'hFFE, 12'd4,  3, 1'b0, 1'b0, 4, 12'hFFE, 12'h001};
        vecs[3] = '{12'h020, 12'd0,  6, 1'b0, 1'b0, 0, 12'h000, 12'h000};
        vecs[4] = '{12'h7F0, 12'd3,  1, 1'b1, 1'b0, 3, 12'h7F0, 12'h7F2};

        reset_b = 1'b0;
        start = 1'b0; result_base_addr = '0; result_count = '0;
        dut_busy = 1'b0; out_ready = 1'b1;
        t_start = 1'b0; t_base = '0; t_count = '0; t_dut_busy = 1'b0;
        t_rdata = '0; t_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dut_run", dut_run, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rd_en", host_sram_read_enable, 0);
        check("rst_tmo_err", timeout_err, 0);
        reset_b = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i], 0);

        // Timeout: DUT never raises busy.
        @(negedge clk);
        t_start = 1'b1;
        run_hi = 0; tmo_k = -1; ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            t_start = 1'b0;
            #1;
            if (t_dut_run) run_hi++;
            if (t_done) ndone++;
            if (tmo_k < 0 && t_timeout_err) tmo_k = k;
            if (k == 16) check("tmo_not_early", t_timeout_err, 0);
        end
        check("tmo_run_cycles", run_hi, 17);
        check("tmo_err_cycle", tmo_k, 17);
        check("tmo_no_done", ndone, 0);
        check("tmo_idle", t_busy, 0);
        check("tmo_run_low", t_dut_run, 0);
        @(negedge clk);
        t_start = 1'b1;
        #1;
        check("tmo_sticky", t_timeout_err, 1);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            t_start = 1'b0;
            t_dut_busy = (k >= 2 && k < 6);
            #1;
            if (k == 0) check("tmo_cleared", t_timeout_err, 0);
            if (t_done) ndone++;
        end
        check("tmo_rerun_done", ndone, 1);
        check("tmo_rerun_err", t_timeout_err, 0);

        // Asynchronous reset in the middle of a drain, then a clean rerun.
        run_vec(10, '{12'h200, 12'd6, 4, 1'b0, 1'b0, 6, 12'h200, 12'h205}, 2);
        #1 reset_b = 1'b0;
        #1;
        check("arst_dut_run", dut_run, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_rd_en", host_sram_read_enable, 0);
        check("arst_addr", host_sram_read_address, 0);
        check("arst_done", done, 0);
        dut_busy = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        run_vec(11, '{12'h200, 12'd6, 4, 1'b0, 1'b0, 6, 12'h200, 12'h205}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
